wb_cmd_initiator: RTL and testbench
===================================

Name: wb_cmd_initiator

Overview:
- Wishbone classic single-transfer initiator that drives the user-area slave port (cyc/stb/we/adr/dat/sel, ack/dat back).
- Accepts one command at a time over a valid/ready command interface and issues the matching bus cycle.
- Returns read data or a timeout error over a valid/ready response interface.
- Used as the on-chip bus exerciser for the user project: commands come from logic-analyzer or GPIO glue, and it drives the slave's wbs_* inputs.

Parameters:
- ADR_W, 32: Wishbone address width.
- DAT_W, 32: Wishbone data width; SEL_W = DAT_W/8.
- TIMEOUT, 255: cycles with strobe asserted and no ack before the cycle is aborted. 0 disables the timeout.
- CNT_W, 16: width of the statistics counters.

Ports:
- wb_clk_i  in  1  sole clock; all logic on the rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  ADR_W  byte address.
- cmd_dat  in  DAT_W  write data.
- cmd_sel  in  SEL_W  byte enables.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_adr_o  out  ADR_W  Wishbone address.
- wbm_dat_o  out  DAT_W  Wishbone write data.
- wbm_sel_o  out  SEL_W  Wishbone byte select.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  DAT_W  slave read data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_dat  out  DAT_W  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout abort.
- txn_count  out  CNT_W  completed acked transfers, wraps.
- err_count  out  CNT_W  timeouts, saturates at all-ones.

Behaviour:
- Reset values (asynchronous on wb_rst_ni low):
  - Registered outputs rsp_valid, rsp_err, rsp_dat, all wbm_* outputs, txn_count and err_count are 0.
  - State is IDLE.
  - cmd_ready is combinational (high only in IDLE), so it reads 1 once reset releases.
  - A reset during BUS drops cyc/stb immediately. No response is produced for that transfer.
- FSM states: IDLE, BUS, RESP. All wbm_* outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready at edge N: latch we/adr/dat/sel into the wbm_* registers and set cyc = stb = 1, so they are visible after edge N. Clear the timer. Go to BUS.
  - wbm_ack_i is ignored.
- BUS:
  - cmd_ready = 0. cyc, stb, we, adr, dat and sel are held stable.
  - Ack sampled high at edge M:
    - cyc = stb = 0 after M.
    - rsp_dat = wbm_dat_i for reads, 0 for writes. rsp_err = 0. rsp_valid = 1.
    - txn_count += 1 (mod 2^CNT_W).
    - Go to RESP.
  - Timeout: no ack with timer == TIMEOUT-1 (TIMEOUT > 0):
    - cyc = stb = 0. rsp_dat = 0, rsp_err = 1, rsp_valid = 1.
    - err_count += 1, saturating.
    - Go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - Otherwise the timer increments.
  - Minimum latency: command accept to rsp_valid is 2 edges, when ack arrives in the first strobe cycle.
- RESP:
  - cmd_ready = 0. rsp_valid held with stable rsp_dat/rsp_err until rsp_valid & rsp_ready at an edge.
  - After that edge: rsp_valid = 0 and the state returns to IDLE. A new command is accepted no earlier than the following edge.
  - Stray wbm_ack_i is ignored.
- Bus rules:
  - wbm_stb_o is never high without wbm_cyc_o.
  - Exactly one strobe per command; no pipelined or burst cycles.
  - wbm_we_o, wbm_adr_o, wbm_dat_o and wbm_sel_o hold their last values in IDLE.

Decomposition:
- Shared package wb_init_pkg holds:
  - the state enum {IDLE, BUS, RESP};
  - default widths (ADR_W, DAT_W);
  - a localparam for the error response data (0).
- One natural sub-module, wb_timeout_counter:
  - inputs: clear, enable;
  - parameter TIMEOUT;
  - output: expired pulse;
  - constant-0 output when TIMEOUT = 0.

Test Plan:
- Write: cmd_we=1, adr=0x3000_0004, dat=0xA5A5_5A5A, sel=0xF; slave acks 2 cycles after stb -> wbm_* stable for 3 cycles, rsp_valid with rsp_err=0 and rsp_dat=0, txn_count=1.
- Read: adr=0x3000_0000; slave acks on the first strobe cycle with wbm_dat_i=0x1234_5678 -> rsp_valid 2 edges after accept, rsp_dat=0x1234_5678.
- Timeout: TIMEOUT=8, slave never acks -> cyc/stb drop after 8 strobe cycles, rsp_err=1, rsp_dat=0, err_count=1, txn_count unchanged.
- Back-pressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_dat stable, cmd_ready=0 throughout. After the handshake, cmd_ready=1 on the next cycle and a queued cmd_valid is accepted.
- Reset mid-BUS: assert wb_rst_ni low during strobe -> cyc/stb=0 immediately (before the next edge), no rsp_valid, counters 0, cmd_ready=1 after release.
- Stray ack in IDLE and RESP, plus ack coinciding with the timeout cycle -> stray acks ignored with counters unchanged. The coincident case returns rsp_err=0 with the read data.

Source files
------------

// File: rtl/wb_init_pkg.sv
// Shared definitions for the Wishbone command initiator.
// Contents: FSM state enum, default bus widths and the data value
// returned on an error response.
package wb_init_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_ADR_W = 32;
  localparam int DEF_DAT_W = 32;

  localparam logic [DEF_DAT_W-1:0] ERR_RSP_DAT = '0;

endpackage

// File: rtl/wb_timeout_counter.sv
// Strobe-cycle watchdog for the initiator.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - reload the timer (command accept)
//   enable     - a strobe cycle is in progress
//   expired    - high during the TIMEOUT-th strobe cycle without reload
// A TIMEOUT of 0 ties expired low and removes the timer.
module wb_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

      logic [TW-1:0] cnt;

      // Down-counter: reaching zero marks the last permitted strobe cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= LOAD;
        end else if (clear) begin
          cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
          cnt <= cnt - TW'(1);
        end
      end

      assign expired = enable && (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer initiator.
// Takes one command over cmd_valid/cmd_ready, runs one bus cycle, and
// returns read data or a timeout error over rsp_valid/rsp_ready.
// Ports:
//   wb_clk_i, wb_rst_ni          - clock, asynchronous active-low reset
//   cmd_valid/ready/we/adr/dat/sel - command interface
//   wbm_cyc/stb/we/adr/dat/sel_o - registered Wishbone master outputs
//   wbm_ack_i, wbm_dat_i         - slave acknowledge and read data
//   rsp_valid/ready/dat/err      - response interface
//   txn_count                    - acked transfers, wrapping
//   err_count                    - timeouts, saturating
//
// state | meaning
// IDLE  | ready for a command, bus idle
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response held until consumed
module wb_cmd_initiator
  import wb_init_pkg::*;
#(
  parameter int ADR_W   = DEF_ADR_W,
  parameter int DAT_W   = DEF_DAT_W,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [DAT_W-1:0]   cmd_dat,
  input  logic [DAT_W/8-1:0] cmd_sel,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  input  logic               wbm_ack_i,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   err_count
);

  localparam int SEL_W = DAT_W / 8;

  state_t             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   txn_q, txn_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               accept;
  logic               expired;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (accept),
    .enable  (state_q == BUS),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      txn_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      txn_q       <= txn_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    txn_d       = txn_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is checked first so a last-cycle ack still completes normally.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          txn_d       = txn_q + CNT_W'(1);
          state_d     = RESP;
        end else if (expired) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = DAT_W'(ERR_RSP_DAT);
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (err_q != '1) begin
            err_d = err_q + CNT_W'(1);
          end
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign txn_count = txn_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed testbench for wb_cmd_initiator (TIMEOUT = 8).
module tb_wb_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] dat_i;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [15:0] txn_count, err_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(
    .ADR_W(32), .DAT_W(32), .TIMEOUT(8), .CNT_W(16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat_o),
    .wbm_sel_o (sel),
    .wbm_ack_i (ack),
    .wbm_dat_i (dat_i),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; ack = 1'b0; dat_i = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({cyc, stb, rsp_valid, rsp_err} !== 4'b0000) $display("FAIL reset_ctl: got %b want 0000", {cyc, stb, rsp_valid, rsp_err});
    else pass_cnt++;
    total_cnt++;
    if ({adr, dat_o, rsp_dat} !== 96'h0) $display("FAIL reset_data: got %h want 0", {adr, dat_o, rsp_dat});
    else pass_cnt++;
    total_cnt++;
    if ({txn_count, err_count} !== 32'h0) $display("FAIL reset_counts: got %h want 0", {txn_count, err_count});
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004;
    cmd_dat = 32'hA5A5_5A5A; cmd_sel = 4'hF; dat_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({cyc, stb, we, adr, dat_o, sel, cmd_ready} !== {3'b111, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 1'b0})
        $display("FAIL wr_bus_cycle%0d: got %b%b%b %h %h %h rdy=%b want 111 30000004 a5a55a5a f rdy=0",
                 i, cyc, stb, we, adr, dat_o, sel, cmd_ready);
      else pass_cnt++;
      if (i == 2) ack = 1'b1;
      @(posedge clk); #1;
    end
    ack = 1'b0;
    total_cnt++;
    if ({cyc, stb, rsp_valid, rsp_err} !== 4'b0010) $display("FAIL wr_rsp_ctl: got %b want 0010", {cyc, stb, rsp_valid, rsp_err});
    else pass_cnt++;
    total_cnt++;
    if (rsp_dat !== 32'h0) $display("FAIL wr_rsp_dat: got %h want 00000000", rsp_dat);
    else pass_cnt++;
    total_cnt++;
    if (txn_count !== 16'd1) $display("FAIL wr_txn_count: got %0d want 1", txn_count);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total_cnt++;
    if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL wr_handshake: got %b want 01", {rsp_valid, cmd_ready});
    else pass_cnt++;
  endtask

  task automatic test_read();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_sel = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0; ack = 1'b1; dat_i = 32'h1234_5678;
    total_cnt++;
    if ({cyc, stb, we, rsp_valid} !== 4'b1100) $display("FAIL rd_strobe: got %b want 1100", {cyc, stb, we, rsp_valid});
    else pass_cnt++;
    @(posedge clk); #1;
    ack = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_err, cyc} !== 3'b100) $display("FAIL rd_rsp_ctl: got %b want 100", {rsp_valid, rsp_err, cyc});
    else pass_cnt++;
    total_cnt++;
    if (rsp_dat !== 32'h1234_5678) $display("FAIL rd_rsp_dat: got %h want 12345678", rsp_dat);
    else pass_cnt++;
    total_cnt++;
    if (txn_count !== 16'd2) $display("FAIL rd_txn_count: got %0d want 2", txn_count);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total_cnt++;
    if ({rsp_valid, cmd_ready, adr, we} !== {2'b01, 32'h3000_0000, 1'b0})
      $display("FAIL rd_idle_hold: got %b%b %h %b want 01 30000000 0", rsp_valid, cmd_ready, adr, we);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010; dat_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      total_cnt++;
      if ({cyc, stb, rsp_valid} !== 3'b110) $display("FAIL to_strobe%0d: got %b want 110", i, {cyc, stb, rsp_valid});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if ({cyc, stb, rsp_valid, rsp_err} !== 4'b0011) $display("FAIL to_rsp_ctl: got %b want 0011", {cyc, stb, rsp_valid, rsp_err});
    else pass_cnt++;
    total_cnt++;
    if (rsp_dat !== 32'h0) $display("FAIL to_rsp_dat: got %h want 00000000", rsp_dat);
    else pass_cnt++;
    total_cnt++;
    if ({err_count, txn_count} !== {16'd1, 16'd2}) $display("FAIL to_counts: got err=%0d txn=%0d want err=1 txn=2", err_count, txn_count);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total_cnt++;
    if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL to_handshake: got %b want 01", {rsp_valid, cmd_ready});
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0008;
    @(posedge clk); #1;
    ack = 1'b1; dat_i = 32'hCAFE_0001;
    // Queue the next command while the response is still pending.
    cmd_we = 1'b1; cmd_adr = 32'h3000_000C; cmd_dat = 32'h0F0F_F0F0; cmd_sel = 4'h3;
    @(posedge clk); #1;
    ack = 1'b0; dat_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({rsp_valid, cmd_ready, rsp_dat, adr} !== {2'b10, 32'hCAFE_0001, 32'h3000_0008})
        $display("FAIL bp_hold%0d: got v=%b rdy=%b %h adr=%h want v=1 rdy=0 cafe0001 adr=30000008",
                 i, rsp_valid, cmd_ready, rsp_dat, adr);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total_cnt++;
    if ({rsp_valid, cmd_ready, cyc} !== 3'b010) $display("FAIL bp_release: got %b want 010", {rsp_valid, cmd_ready, cyc});
    else pass_cnt++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total_cnt++;
    if ({cyc, we, adr, dat_o, sel} !== {2'b11, 32'h3000_000C, 32'h0F0F_F0F0, 4'h3})
      $display("FAIL bp_queued_accept: got %b%b %h %h %h want 11 3000000c 0f0ff0f0 3", cyc, we, adr, dat_o, sel);
    else pass_cnt++;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_dat, txn_count} !== {1'b1, 32'h0, 16'd4})
      $display("FAIL bp_queued_rsp: got v=%b %h txn=%0d want v=1 00000000 txn=4", rsp_valid, rsp_dat, txn_count);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_stray_ack();
    ack = 1'b1; dat_i = 32'h7777_7777;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({cyc, rsp_valid, cmd_ready, txn_count} !== {3'b001, 16'd4})
      $display("FAIL stray_idle: got cyc=%b v=%b rdy=%b txn=%0d want 0 0 1 4", cyc, rsp_valid, cmd_ready, txn_count);
    else pass_cnt++;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0014;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    ack = 1'b0;
    total_cnt++;
    if ({rsp_valid, cmd_ready, cyc, rsp_dat, txn_count} !== {3'b100, 32'h7777_7777, 16'd5})
      $display("FAIL stray_resp: got v=%b rdy=%b cyc=%b %h txn=%0d want 1 0 0 77777777 5",
               rsp_valid, cmd_ready, cyc, rsp_dat, txn_count);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    // Ack arrives in the eighth strobe cycle, the same cycle the timer expires.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    total_cnt++;
    if (cyc !== 1'b1) $display("FAIL coinc_pre: got cyc=%b want 1", cyc);
    else pass_cnt++;
    ack = 1'b1; dat_i = 32'h0BAD_F00D;
    @(posedge clk); #1;
    ack = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'h0BAD_F00D})
      $display("FAIL coinc_rsp: got v=%b err=%b %h want 1 0 0badf00d", rsp_valid, rsp_err, rsp_dat);
    else pass_cnt++;
    total_cnt++;
    if ({txn_count, err_count} !== {16'd6, 16'd1}) $display("FAIL coinc_counts: got txn=%0d err=%0d want 6 1", txn_count, err_count);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0030; cmd_dat = 32'h1111_2222;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total_cnt++;
    if ({cyc, stb} !== 2'b11) $display("FAIL rst_mid_pre: got %b want 11", {cyc, stb});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({cyc, stb, rsp_valid} !== 3'b000) $display("FAIL rst_mid_drop: got %b want 000", {cyc, stb, rsp_valid});
    else pass_cnt++;
    total_cnt++;
    if ({txn_count, err_count} !== 32'h0) $display("FAIL rst_mid_counts: got txn=%0d err=%0d want 0 0", txn_count, err_count);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({cmd_ready, rsp_valid, cyc} !== 3'b100) $display("FAIL rst_mid_release: got %b want 100", {cmd_ready, rsp_valid, cyc});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_pressure();
    test_stray_ack();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
